plaintext_checker: RTL and testbench

PLAINTEXT_CHECKER -- requirements
Module: plaintext_checker

---
 rtl/plaintext_checker.sv | 114 +++++++++++
 tb/tb_plaintext_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plaintext_checker.sv
// Plaintext checker: snoops the decrypted-memory write port of a decryption
// core and decides whether the candidate key produced readable text
// (lower-case letters and spaces, written in address order 0..MSG_LEN-1).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no attempt in progress, snooped writes ignored
// CHECK   | accepting in-order plaintext bytes for the latched key
// VERDICT | attempt decided; done/abort/pass issued on exit to IDLE
module plaintext_checker #(
  parameter int MSG_LEN = 32,
  parameter int KEY_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_i,
  input  logic             wr_en,
  input  logic [7:0]       wr_addr,
  input  logic [7:0]       wr_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             abort,
  output logic             found,
  output logic [KEY_W-1:0] found_key,
  output logic [7:0]       byte_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    VERDICT = 2'd2
  } state_t;

  localparam logic [7:0] LAST_ADDR = 8'(MSG_LEN - 1);

  state_t           state;
  logic [KEY_W-1:0] key_q;
  logic             verdict_pass;
  logic             byte_ok;
  logic             in_order;

  // Printable-text classifier: a-z or space.
  always_comb begin
    byte_ok  = ((wr_data >= 8'h61) && (wr_data <= 8'h7A)) || (wr_data == 8'h20);
    in_order = (wr_addr == byte_count);
  end

  // Attempt sequencer; all outputs are registered. start restarts from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      key_q        <= '0;
      verdict_pass <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      abort        <= 1'b0;
      found        <= 1'b0;
      found_key    <= '0;
      byte_count   <= 8'd0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (start) begin
        state        <= CHECK;
        key_q        <= key_i;
        verdict_pass <= 1'b0;
        busy         <= 1'b1;
        pass         <= 1'b0;
        byte_count   <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          CHECK: begin
            if (wr_en) begin
              if (in_order && byte_ok) begin
                // Saturate so MSG_LEN=256 cannot wrap the count back to zero.
                if (byte_count != 8'hFF) byte_count <= byte_count + 8'd1;
                if (wr_addr == LAST_ADDR) begin
                  state        <= VERDICT;
                  verdict_pass <= 1'b1;
                end
              end else begin
                state        <= VERDICT;
                verdict_pass <= 1'b0;
              end
            end
          end
          VERDICT: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            abort <= ~verdict_pass;
            pass  <= verdict_pass;
            // Only the first passing key is kept.
            if (verdict_pass && !found) begin
              found     <= 1'b1;
              found_key <= key_q;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plaintext_checker.sv
// Self-checking bench for plaintext_checker: directed scenarios plus random
// attempts, each scored by a transaction-level model of the attempt.
module tb_plaintext_checker;

  localparam int MSG_LEN = 32;
  localparam int KEY_W   = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [KEY_W-1:0] key_i;
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             busy, done, pass, abort, found;
  logic [KEY_W-1:0] found_key;
  logic [7:0]       byte_count;

  plaintext_checker #(.MSG_LEN(MSG_LEN), .KEY_W(KEY_W)) dut (
    .clk(clk), .reset(reset), .start(start), .key_i(key_i),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .pass(pass), .abort(abort),
    .found(found), .found_key(found_key), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic             exp_found;
  logic [KEY_W-1:0] exp_fkey;

  bit         q_en[$];
  logic [7:0] q_addr[$];
  logic [7:0] q_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input logic [7:0] addr, input logic [7:0] data);
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
  endtask

  function automatic bit is_text(input logic [7:0] d);
    return ((d >= 8'h61) && (d <= 8'h7A)) || (d == 8'h20);
  endfunction

  function automatic logic [7:0] rand_text();
    int r;
    r = $urandom % 27;
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rand_junk();
    logic [7:0] d;
    d = 8'($urandom);
    while (is_text(d)) d = 8'($urandom);
    return d;
  endfunction

  task automatic q_clear();
    q_en.delete();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic q_push(input bit en, input logic [7:0] addr, input logic [7:0] data);
    q_en.push_back(en);
    q_addr.push_back(addr);
    q_data.push_back(data);
  endtask

  task automatic q_text(input string s);
    for (int i = 0; i < s.len(); i++) q_push(1'b1, 8'(i), 8'(s[i]));
  endtask

  // Start an attempt and play the queued write cycles. The model keeps the
  // count of in-order text bytes and stops at the first deciding write.
  // If the queue runs out undecided, the attempt is left open.
  task automatic run_attempt(input logic [KEY_W-1:0] key, input bit wr_on_start);
    int cnt;
    bit decided;
    bit dpass;
    cnt     = 0;
    decided = 1'b0;
    dpass   = 1'b0;
    start = 1'b1;
    key_i = key;
    drive(wr_on_start, 8'h00, 8'h61);
    tick();
    start = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    chk("start_bc", byte_count, 0);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_pass", pass, 0);
    for (int i = 0; i < q_en.size(); i++) begin
      drive(q_en[i], q_addr[i], q_data[i]);
      tick();
      if (q_en[i]) begin
        if ((int'(q_addr[i]) == cnt) && is_text(q_data[i])) begin
          cnt++;
          if (cnt == MSG_LEN) begin
            decided = 1'b1;
            dpass   = 1'b1;
          end
        end else begin
          decided = 1'b1;
          dpass   = 1'b0;
        end
      end
      chk("chk_bc", byte_count, 32'(cnt));
      chk("chk_done", done, 0);
      chk("chk_abort", abort, 0);
      chk("chk_busy", busy, 1);
      if (decided) break;
    end
    drive(1'b0, 8'h00, 8'h00);
    if (!decided) return;
    // Verdict cycle: a write here must be ignored.
    drive(1'b1, 8'(cnt), 8'h61);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    if (dpass && !exp_found) begin
      exp_found = 1'b1;
      exp_fkey  = key;
    end
    chk("v_done", done, 1);
    chk("v_abort", abort, {31'd0, ~dpass});
    chk("v_pass", pass, {31'd0, dpass});
    chk("v_found", found, {31'd0, exp_found});
    chk("v_fkey", found_key, 32'(exp_fkey));
    chk("v_bc", byte_count, 32'(cnt));
    chk("v_busy", busy, 0);
    tick();
    chk("post_done", done, 0);
    chk("post_abort", abort, 0);
    chk("post_pass", pass, {31'd0, dpass});
    chk("post_busy", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b1;
    key_i = 24'hABCDEF;
    drive(1'b1, 8'h00, 8'h61);
    tick();
    start = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    exp_found = 1'b0;
    exp_fkey  = '0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_abort", abort, 0);
    chk("rst_found", found, 0);
    chk("rst_fkey", found_key, 0);
    chk("rst_bc", byte_count, 0);
    reset = 1'b0;
    tick();
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_done", done, 0);
  endtask

  initial begin
    int gc;
    int r;
    int maxlen;
    bit stop;
    reset = 1'b1;
    start = 1'b0;
    key_i = '0;
    drive(1'b0, 8'h00, 8'h00);
    exp_found = 1'b0;
    exp_fkey  = '0;
    tick();
    do_reset();

    // Full passing message.
    q_clear();
    q_text("the quick brown fox jumps over t");
    run_attempt(24'h000123, 1'b0);

    // Invalid byte after one good byte.
    q_clear();
    q_push(1'b1, 8'd0, 8'h61);
    q_push(1'b1, 8'd1, 8'h41);
    run_attempt(24'h000777, 1'b0);

    // Out-of-order write, with idle cycles in between.
    q_clear();
    q_push(1'b1, 8'd0, 8'h61);
    q_push(1'b0, 8'd1, 8'h62);
    q_push(1'b0, 8'd5, 8'h00);
    q_push(1'b1, 8'd2, 8'h61);
    run_attempt(24'h000888, 1'b0);

    // Reset after 5 valid bytes discards the attempt.
    q_clear();
    q_text("abcde");
    run_attempt(24'h0000AA, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_nodone", done, 0);
    end

    // Restart mid-attempt; the write in the start cycle is dropped.
    q_clear();
    q_text("hello worl");
    run_attempt(24'h00000A, 1'b0);
    q_clear();
    q_text("pack my box with five dozen liqu");
    run_attempt(24'h00000B, 1'b1);

    // Later passes keep the first found key.
    do_reset();
    q_clear();
    q_text("sphinx of black quartz judge my ");
    run_attempt(24'h000005, 1'b0);
    run_attempt(24'h000009, 1'b0);

    // Random attempts, some abandoned by a restart.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      q_clear();
      gc     = 0;
      stop   = 1'b0;
      maxlen = ($urandom % 8 == 0) ? int'($urandom_range(1, 20)) : 90;
      while (!stop && q_en.size() < maxlen) begin
        r = $urandom % 100;
        if (r < 15) begin
          q_push(1'b0, 8'($urandom), 8'($urandom));
        end else if (r < 17) begin
          q_push(1'b1, 8'(gc), rand_junk());
          stop = 1'b1;
        end else if (r < 19) begin
          q_push(1'b1, 8'(gc + 1 + $urandom % 5), rand_text());
          stop = 1'b1;
        end else begin
          q_push(1'b1, 8'(gc), rand_text());
          gc++;
          if (gc == MSG_LEN) stop = 1'b1;
        end
      end
      run_attempt(KEY_W'($urandom), bit'($urandom % 4 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
